// File: rtl/change_dispenser.sv
// change_dispenser: emits quarter/dime/nickel pulses, largest coin first, for a latched amount.
// Optional COIN_INVENTORY_EN adds per-coin stock counters that gate coin selection.
module change_dispenser #(
  parameter int AMT_W     = 9,
  parameter int PULSE_GAP = 1,
  parameter int INV_W     = 8,
  parameter int INIT_INV  = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  input  logic             refill,
  output logic             busy,
  output logic             done,
  output logic             short,
  output logic [AMT_W-1:0] remaining,
  output logic             outquarter,
  output logic             outdime,
  output logic             outnickel
);
  typedef enum logic [2:0] {IDLE, SELECT, PULSE, GAP, FINISH} state_t;
  typedef enum logic [1:0] {C_Q, C_D, C_N} coin_t;
  localparam int GW = PULSE_GAP > 1 ? $clog2(PULSE_GAP) : 1;
  state_t state;
  coin_t coin;
  logic [GW-1:0] gap_cnt;
  logic q_ok, d_ok, n_ok;
  logic [AMT_W-1:0] val;
`ifdef COIN_INVENTORY_EN
  logic [INV_W-1:0] inv_q, inv_d, inv_n;
  always_comb begin
    q_ok = remaining >= AMT_W'(25) && inv_q != '0;
    d_ok = remaining >= AMT_W'(10) && inv_d != '0;
    n_ok = remaining >= AMT_W'(5) && inv_n != '0;
  end
  // refill takes priority over a same-cycle decrement
  always_ff @(posedge clk) begin
    if (rst || refill) begin
      inv_q <= INV_W'(INIT_INV);
      inv_d <= INV_W'(INIT_INV);
      inv_n <= INV_W'(INIT_INV);
    end else if (state == PULSE) begin
      inv_q <= coin == C_Q ? inv_q - 1'b1 : inv_q;
      inv_d <= coin == C_D ? inv_d - 1'b1 : inv_d;
      inv_n <= coin == C_N ? inv_n - 1'b1 : inv_n;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = refill | (INV_W == 0) | (INIT_INV == 0);
  always_comb begin
    q_ok = remaining >= AMT_W'(25);
    d_ok = remaining >= AMT_W'(10);
    n_ok = remaining >= AMT_W'(5);
  end
`endif
  always_comb val = coin == C_Q ? AMT_W'(25) : coin == C_D ? AMT_W'(10) : AMT_W'(5);
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      coin       <= C_Q;
      gap_cnt    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      short      <= 1'b0;
      remaining  <= '0;
      outquarter <= 1'b0;
      outdime    <= 1'b0;
      outnickel  <= 1'b0;
    end else begin
      done       <= 1'b0;
      outquarter <= 1'b0;
      outdime    <= 1'b0;
      outnickel  <= 1'b0;
      case (state)
        IDLE: begin
          // a start coinciding with the done pulse is dropped
          busy <= start && !done;
          if (start && !done) begin
            remaining <= amount;
            short     <= 1'b0;
            state     <= SELECT;
          end
        end
        SELECT: begin
          coin  <= q_ok ? C_Q : d_ok ? C_D : C_N;
          state <= (q_ok || d_ok || n_ok) ? PULSE : FINISH;
        end
        PULSE: begin
          outquarter <= coin == C_Q;
          outdime    <= coin == C_D;
          outnickel  <= coin == C_N;
          remaining  <= remaining - val;
          gap_cnt    <= '0;
          state      <= PULSE_GAP > 0 ? GAP : SELECT;
        end
        GAP: begin
          if (gap_cnt == GW'(PULSE_GAP - 1)) state <= SELECT;
          else gap_cnt <= gap_cnt + 1'b1;
        end
        FINISH: begin
          done  <= 1'b1;
          short <= remaining != '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: randomized + directed scoreboard bench for change_dispenser.
module tb_change_dispenser;
  localparam int AMT_W = 9, GAP = 1, INV_W = 8, INIT_INV = 20;
  localparam int SPACING = 2 + GAP;
  logic clk = 0, rst = 1, start = 0, refill = 0;
  logic [AMT_W-1:0] amount = '0;
  logic busy, done, short, outquarter, outdime, outnickel;
  logic [AMT_W-1:0] remaining;
  typedef struct {int kind; int cyc; int rem; int sh;} ev_t;
  ev_t exp_q[$];
  int cyc = 0, checks = 0, errors = 0;
  int inv[3];
  int last_rem = 0;
  change_dispenser #(.AMT_W(AMT_W), .PULSE_GAP(GAP), .INV_W(INV_W), .INIT_INV(INIT_INV)) dut (
    .clk(clk), .rst(rst), .start(start), .amount(amount), .refill(refill), .busy(busy),
    .done(done), .short(short), .remaining(remaining), .outquarter(outquarter),
    .outdime(outdime), .outnickel(outnickel));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic reset_inv();
`ifdef COIN_INVENTORY_EN
    foreach (inv[i]) inv[i] = INIT_INV;
`else
    foreach (inv[i]) inv[i] = 1 << 30;
`endif
  endtask
  // Greedy change-making from the rules; request accepted at posedge number c
  task automatic predict(input int amt, input int c);
    int values[3] = '{25, 10, 5};
    int rem = amt, k = 0, pick;
    forever begin
      pick = -1;
      for (int j = 2; j >= 0; j--) if (rem >= values[j] && inv[j] > 0) pick = j;
      if (pick < 0) break;
      exp_q.push_back('{pick, c + 2 + k * SPACING, 0, 0});
      rem -= values[pick];
      inv[pick]--;
      k++;
    end
    exp_q.push_back('{3, c + 2 + k * SPACING, rem, int'(rem != 0)});
    last_rem = rem;
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      int kind;
      ev_t e;
      if (int'(outquarter) + int'(outdime) + int'(outnickel) + int'(done) > 1)
        check("one_hot_outputs", 0, 1);
      kind = outquarter ? 0 : outdime ? 1 : outnickel ? 2 : done ? 3 : -1;
      if (kind >= 0) begin
        if (exp_q.size() == 0) check("unexpected_event_kind", kind, -1);
        else begin
          e = exp_q.pop_front();
          check("event_kind", kind, e.kind);
          check("event_cycle", cyc, e.cyc);
          if (kind == 3) begin
            check("done_remaining", int'(remaining), e.rem);
            check("done_short", int'(short), e.sh);
            check("done_busy", int'(busy), 1);
          end
        end
      end
    end
  end
  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask
  task automatic run(input int amt);
    int c;
    @(negedge clk);
    start = 1;
    amount = AMT_W'(amt);
    c = cyc + 1;
    predict(amt, c);
    @(negedge clk);
    start = 0;
    check("busy_after_start", int'(busy), 1);
    drain();
  endtask
  initial begin
    int c, n;
    reset_inv();
    repeat (2) @(negedge clk);
    check("reset_outputs", int'({busy, done, short, outquarter, outdime, outnickel}), 0);
    check("reset_remaining", int'(remaining), 0);
    rst = 0;
    run(25);
    run(40);
    run(0);
    run(33);
    // start while busy is ignored
    @(negedge clk);
    start = 1; amount = 75; predict(75, cyc + 1);
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    start = 1; amount = 10;
    @(negedge clk);
    start = 0;
    drain();
    // start coinciding with done is ignored
    @(negedge clk);
    start = 1; amount = 30; predict(30, cyc + 1);
    @(negedge clk);
    start = 0;
    n = 0;
    while (!done && n < 100) begin @(negedge clk); n++; end
    check("done_seen", int'(done), 1);
    start = 1; amount = 5;
    @(negedge clk);
    start = 0;
    repeat (10) @(negedge clk);
    check("ignored_start_remaining", int'(remaining), last_rem);
    check("ignored_start_busy", int'(busy), 0);
    // reset after the second quarter aborts the request
    @(negedge clk);
    start = 1; amount = 150; c = cyc + 1; predict(150, c);
    @(negedge clk);
    start = 0;
    n = 0;
    while (cyc != c + 2 + SPACING && n < 100) begin @(negedge clk); n++; end
    check("second_quarter_reached", cyc, c + 2 + SPACING);
    #1 rst = 1;
    exp_q.delete();
    reset_inv();
    @(negedge clk);
    check("abort_outputs", int'({busy, done, short, outquarter, outdime, outnickel}), 0);
    check("abort_remaining", int'(remaining), 0);
    rst = 0;
    repeat (20) @(negedge clk);
`ifdef COIN_INVENTORY_EN
    run(500);
    run(50);
    @(negedge clk);
    refill = 1;
    reset_inv();
    @(negedge clk);
    refill = 0;
    run(50);
`endif
    for (int i = 0; i < 25; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run(int'($urandom_range(0, 511)));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
